// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster timing, HDMI period sequencing and data-island grant handshake
module hdmi_period_scheduler #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   DI_OFFSET   = 4,
  parameter int   MAX_PACKETS = 2
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        di_req,
  input  logic [2:0]  di_n_packets,
  output logic        di_ack,
  output logic        di_data_en,
  output logic        di_pkt_start,
  output logic        active_video,
  output logic        video_gb,
  output logic        data_island_gb,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  ctl,
  output logic [10:0] x,
  output logic [9:0]  y
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DS = H_ACTIVE + DI_OFFSET;
  localparam logic [10:0] HA1  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HA   = 11'(H_ACTIVE);
  localparam logic [10:0] HEND = 11'(H_TOTAL - 1);
  localparam logic [10:0] HPRE = 11'(H_TOTAL - 11);
  localparam logic [10:0] HGB  = 11'(H_TOTAL - 3);
  localparam logic [10:0] DS1  = 11'(DS - 1);
  localparam logic [10:0] DLGB = 11'(DS + 7);
  localparam logic [10:0] DDAT = 11'(DS + 9);
  localparam logic [10:0] PK0  = 11'(DS + 10);
  localparam logic [10:0] HS0  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VEND = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VA1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VS0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  MP   = 3'(MAX_PACKETS);
  typedef enum logic [2:0] {CTRL, DI_PRE, DI_LGB, DI_DATA, DI_TGB, VID_PRE, VID_GB, VIDEO} state_t;
  state_t      state_q, state_d;
  logic [10:0] h_q, h_d, x_q, x_d, dat_end;
  logic [9:0]  v_q, v_d, y_q, y_d;
  logic [2:0]  n_q, n_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [4:0]  pkt_off;
  logic        pre_vid;
  logic ack_q, ack_d, den_q, den_d, pkt_q, pkt_d, av_q, av_d, vgb_q, vgb_d, dgb_q, dgb_d, hs_q, hs_d, vs_q, vs_d;
  always_comb begin
    h_d = h_q == HEND ? 11'd0 : h_q + 11'd1;
    v_d = h_q != HEND ? v_q : v_q == VEND ? 10'd0 : v_q + 10'd1;
    n_d = h_q == HA1 ? (di_req ? (di_n_packets > MP ? MP : di_n_packets) : 3'd0) : n_q;
    pre_vid = v_q == VEND || v_q < VA1;
    dat_end = DDAT + {3'b0, n_q, 5'b0};
    pkt_off = 5'(h_q - PK0);
    state_d = state_q;
    case (state_q)
      CTRL:    state_d = (h_q == HPRE && pre_vid) ? VID_PRE : (h_q == DS1 && n_q != 3'd0) ? DI_PRE : CTRL;
      VID_PRE: state_d = h_q == HGB ? VID_GB : VID_PRE;
      VID_GB:  state_d = h_q == HEND ? VIDEO : VID_GB;
      VIDEO:   state_d = h_q == HA1 ? CTRL : VIDEO;
      DI_PRE:  state_d = h_q == DLGB ? DI_LGB : DI_PRE;
      DI_LGB:  state_d = h_q == DDAT ? DI_DATA : DI_LGB;
      DI_DATA: state_d = h_q == dat_end ? DI_TGB : DI_DATA;
      DI_TGB:  state_d = h_q == dat_end + 11'd2 ? CTRL : DI_TGB;
      default: state_d = CTRL;
    endcase
    ack_d = h_q == HA && n_q != 3'd0;
    av_d  = state_q == VIDEO;
    vgb_d = state_q == VID_GB;
    dgb_d = state_q == DI_LGB || state_q == DI_TGB;
    den_d = state_q == DI_DATA;
    pkt_d = state_q == DI_DATA && pkt_off == 5'd0;
    ctl_d = state_q == VID_PRE ? 4'b0001 : state_q == DI_PRE ? 4'b0101 : 4'b0000;
    hs_d  = (h_q >= HS0 && h_q < HS1) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_q >= VS0 && v_q < VS1) ? SYNC_POL : ~SYNC_POL;
    x_d   = h_q;
    y_d   = v_q;
  end
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_q     <= HA;
      v_q     <= VEND;
      state_q <= CTRL;
      n_q     <= 3'd0;
      ack_q   <= 1'b0;
      av_q    <= 1'b0;
      vgb_q   <= 1'b0;
      dgb_q   <= 1'b0;
      den_q   <= 1'b0;
      pkt_q   <= 1'b0;
      ctl_q   <= 4'd0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      n_q     <= n_d;
      ack_q   <= ack_d;
      av_q    <= av_d;
      vgb_q   <= vgb_d;
      dgb_q   <= dgb_d;
      den_q   <= den_d;
      pkt_q   <= pkt_d;
      ctl_q   <= ctl_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  assign di_ack         = ack_q;
  assign di_data_en     = den_q;
  assign di_pkt_start   = pkt_q;
  assign active_video   = av_q;
  assign video_gb       = vgb_q;
  assign data_island_gb = dgb_q;
  assign hsync          = hs_q;
  assign vsync          = vs_q;
  assign ctl            = ctl_q;
  assign x              = x_q;
  assign y              = y_q;
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: directed self-checking bench with a per-cycle raster model
module tb_hdmi_period_scheduler;
  logic        pixel_clk, rst, di_req;
  logic [2:0]  di_n_packets;
  logic        di_ack, di_data_en, di_pkt_start, active_video, video_gb, data_island_gb, hsync, vsync;
  logic [3:0]  ctl;
  logic [10:0] x;
  logic [9:0]  y;
  int errors = 0, checks = 0;
  int ex, ey, mn, cyc = 0, f0 = 0, run = 0;
  int ax, ay, ly, acks;
  hdmi_period_scheduler #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .di_req(di_req), .di_n_packets(di_n_packets),
    .di_ack(di_ack), .di_data_en(di_data_en), .di_pkt_start(di_pkt_start),
    .active_video(active_video), .video_gb(video_gb), .data_island_gb(data_island_gb),
    .hsync(hsync), .vsync(vsync), .ctl(ctl), .x(x), .y(y)
  );
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h (x=%0d y=%0d)", tag, got, exp, x, y);
    end
  endtask
  task automatic tick();
    bit pv, isl;
    int de;
    if (ex == 638) mn = (di_req && di_n_packets != 3'd0) ? (di_n_packets > 3'd2 ? 2 : int'(di_n_packets)) : 0;
    @(posedge pixel_clk); #1;
    cyc++;
    if (ex == 799) begin
      ex = 0;
      ey = (ey == 9) ? 0 : ey + 1;
    end else ex++;
    pv  = ey == 9 || ey < 3;
    isl = mn != 0;
    de  = 654 + 32 * mn;
    chk("x", 32'(x), 32'(ex));
    chk("y", 32'(y), 32'(ey));
    chk("hsync", 32'(hsync), 32'(!(ex >= 656 && ex <= 751)));
    chk("vsync", 32'(vsync), 32'(!(ey == 6 || ey == 7)));
    chk("active_video", 32'(active_video), 32'(ex < 640 && ey < 4));
    chk("video_gb", 32'(video_gb), 32'(pv && ex >= 798));
    chk("ctl", 32'(ctl), (pv && ex >= 790 && ex <= 797) ? 32'd1 : (isl && ex >= 644 && ex <= 651) ? 32'd5 : 32'd0);
    chk("di_ack", 32'(di_ack), 32'(isl && ex == 640));
    chk("island_gb", 32'(data_island_gb), 32'(isl && (ex == 652 || ex == 653 || ex == de || ex == de + 1)));
    chk("di_data_en", 32'(di_data_en), 32'(isl && ex >= 654 && ex < de));
    chk("pkt_start", 32'(di_pkt_start), 32'(isl && ex >= 654 && ex < de && (ex - 654) % 32 == 0));
    chk("exclusive", 32'($countones({active_video, video_gb, data_island_gb, di_data_en}) <= 1), 32'd1);
    if ((video_gb || data_island_gb) && run > 0) chk("ctrl_before_gb", 32'(run >= 12), 32'd1);
    run = (active_video || video_gb || data_island_gb || di_data_en) ? 0 : run + 1;
    if (active_video && x == 11'd0 && y == 10'd0) begin
      if (f0 != 0) chk("frame_period", 32'(cyc - f0), 32'd8000);
      f0 = cyc;
    end
  endtask
  task automatic run_until(input int tx, input int ty);
    bit hit = 0;
    for (int k = 0; k < 20000 && !hit; k++) begin
      tick();
      if (ex == tx && (ty < 0 || ey == ty)) hit = 1;
    end
    chk("reach_point", 32'(hit), 32'd1);
  endtask
  task automatic wait_ack();
    bit got = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      tick();
      if (di_ack) begin
        got = 1;
        ax = int'(x);
        ay = int'(y);
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask
  task automatic model_reset();
    ex = 639;
    ey = 9;
    mn = 0;
    run = 0;
    f0 = 0;
  endtask
  initial begin
    rst = 1'b1;
    di_req = 1'b0;
    di_n_packets = 3'd0;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({active_video, video_gb, data_island_gb, di_data_en, di_pkt_start, di_ack}), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 16800; k++) tick();
    di_req = 1'b1;
    di_n_packets = 3'd2;
    wait_ack();
    di_req = 1'b0;
    chk("ack_x_n2", 32'(ax), 32'd640);
    run_until(720, -1);
    di_req = 1'b1;
    di_n_packets = 3'd7;
    wait_ack();
    di_req = 1'b0;
    chk("ack_x_n7", 32'(ax), 32'd640);
    run_until(720, -1);
    run_until(600, -1);
    di_req = 1'b1;
    di_n_packets = 3'd0;
    acks = 0;
    for (int k = 0; k < 1600; k++) begin
      tick();
      if (di_ack) acks++;
    end
    chk("no_ack_n0", 32'(acks), 32'd0);
    di_req = 1'b0;
    run_until(700, -1);
    ly = ey;
    di_req = 1'b1;
    di_n_packets = 3'd1;
    wait_ack();
    di_req = 1'b0;
    chk("late_ack_x", 32'(ax), 32'd640);
    chk("late_ack_y", 32'(ay), 32'((ly + 1) % 10));
    run_until(100, 5);
    di_req = 1'b1;
    di_n_packets = 3'd2;
    wait_ack();
    di_req = 1'b0;
    chk("vblank_ack_y", 32'(ay), 32'd5);
    run_until(720, 5);
    run_until(100, 1);
    di_req = 1'b1;
    di_n_packets = 3'd2;
    wait_ack();
    di_req = 1'b0;
    run_until(690, -1);
    chk("pre_rst_den", 32'(di_data_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_flags", 32'({active_video, video_gb, data_island_gb, di_data_en, di_pkt_start, di_ack}), 32'd0);
    chk("arst_sync", 32'({hsync, vsync}), 32'd3);
    chk("arst_ctl", 32'(ctl), 32'd0);
    chk("arst_xy", 32'({x, y}), 32'd0);
    repeat (2) @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_until(700, 0);
    run_until(100, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
